// File: rtl/snack_pkg.sv
// Shared definitions for the snack dispenser: servo control codes and
// the dispense sequencer state encoding.
package snack_pkg;

  localparam logic [1:0] SERVO_STOP   = 2'b00;
  localparam logic [1:0] SERVO_PUSH   = 2'b01;
  localparam logic [1:0] SERVO_REVERT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH     = 3'd1,
    ST_SETTLE_A = 3'd2,
    ST_REVERT   = 3'd3,
    ST_SETTLE_B = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dispense_phase_timer.sv
// Loadable 32-bit phase down-counter; expired pulses for one cycle in the
// last cycle of a phase of length value (a value of 0 behaves like 1).
module dispense_phase_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expired
);

  logic [31:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      cnt_d   = (value == 32'd0) ? 32'd0 : value - 32'd1;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == 32'd0) armed_d = 1'b0;
      else                cnt_d   = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expired = armed_q && (cnt_q == 32'd0);

endmodule

// File: rtl/dispense_sequencer.sv
// Runs PUSH -> SETTLE_A -> REVERT -> SETTLE_B servo cycles on one slot,
// one cycle per dispensed unit, holding every other slot at STOP.
//
// state       | meaning
// ST_IDLE     | ready for a command, all servos STOP
// ST_PUSH     | active slot pushing a unit out
// ST_SETTLE_A | STOP dwell after the push
// ST_REVERT   | active slot retracting
// ST_SETTLE_B | STOP dwell after retract; unit ends here
module dispense_sequencer
  import snack_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = 4,
  parameter int PUSH_MS   = 800,
  parameter int SETTLE_MS = 200,
  parameter int REVERT_MS = 800,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SLOT_W-1:0]      cmd_slot,
  input  logic [CNT_W-1:0]       cmd_count,
  input  logic                   abort,
  output logic [2*NUM_SLOTS-1:0] servo_ctrl,
  output logic                   busy,
  output logic [CNT_W-1:0]       units_left,
  output logic                   done,
  output logic                   err
);

  localparam logic [31:0] PUSH_CYC   = 32'((CLK_FREQ / 1000) * PUSH_MS);
  localparam logic [31:0] SETTLE_CYC = 32'((CLK_FREQ / 1000) * SETTLE_MS);
  localparam logic [31:0] REVERT_CYC = 32'((CLK_FREQ / 1000) * REVERT_MS);
  localparam logic [SLOT_W:0] NUM_SLOTS_W = (SLOT_W + 1)'(NUM_SLOTS);

  seq_state_e             state_q, state_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [CNT_W-1:0]       units_q, units_d;
  logic                   abort_q, abort_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [2*NUM_SLOTS-1:0] servo_ctrl_q, servo_ctrl_d;
  logic                   tmr_load;
  logic [31:0]            tmr_value;
  logic                   tmr_expired;
  logic                   cmd_bad;
  logic [1:0]             code_d;

  dispense_phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  assign cmd_bad = {1'b0, cmd_slot} >= NUM_SLOTS_W;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    units_d   = units_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = PUSH_CYC;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (cmd_valid) begin
          if (cmd_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_PUSH;
            slot_d    = cmd_slot;
            units_d   = cmd_count;
            tmr_load  = 1'b1;
            tmr_value = PUSH_CYC;
          end
        end
      end
      ST_PUSH: begin
        // Abort mid-push retracts right away with a full revert phase.
        if (abort) begin
          abort_d   = 1'b1;
          state_d   = ST_REVERT;
          tmr_load  = 1'b1;
          tmr_value = REVERT_CYC;
        end else if (tmr_expired) begin
          state_d   = ST_SETTLE_A;
          tmr_load  = 1'b1;
          tmr_value = SETTLE_CYC;
        end
      end
      ST_SETTLE_A: begin
        if (abort) abort_d = 1'b1;
        if (tmr_expired) begin
          state_d   = ST_REVERT;
          tmr_load  = 1'b1;
          tmr_value = REVERT_CYC;
        end
      end
      ST_REVERT: begin
        if (abort) abort_d = 1'b1;
        if (tmr_expired) begin
          state_d   = ST_SETTLE_B;
          tmr_load  = 1'b1;
          tmr_value = SETTLE_CYC;
        end
      end
      ST_SETTLE_B: begin
        if (abort) abort_d = 1'b1;
        if (tmr_expired) begin
          if (abort_q || abort || units_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            units_d = '0;
            done_d  = 1'b1;
            err_d   = abort_q || abort;
          end else begin
            state_d   = ST_PUSH;
            units_d   = units_q - CNT_W'(1);
            tmr_load  = 1'b1;
            tmr_value = PUSH_CYC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    code_d = SERVO_STOP;
    if (state_d == ST_PUSH)   code_d = SERVO_PUSH;
    if (state_d == ST_REVERT) code_d = SERVO_REVERT;
    servo_ctrl_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_d == SLOT_W'(i)) servo_ctrl_d[2*i +: 2] = code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      units_q      <= '0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      servo_ctrl_q <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      units_q      <= units_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
      err_q        <= err_d;
      servo_ctrl_q <= servo_ctrl_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE) && !rst;
  assign busy       = (state_q != ST_IDLE);
  assign units_left = units_q;
  assign done       = done_q;
  assign err        = err_q;
  assign servo_ctrl = servo_ctrl_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with short phases (U = 13 cycles).
// NUM_SLOTS=5 so that slot 5 is expressible on the 3-bit slot port and out of range.
module tb_dispense_sequencer;

  localparam int NS = 5;
  localparam int SW = $clog2(NS);

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SW-1:0]   cmd_slot;
  logic [3:0]      cmd_count;
  logic            abort;
  logic [2*NS-1:0] servo_ctrl;
  logic            busy;
  logic [3:0]      units_left;
  logic            done;
  logic            err;

  int total = 0;
  int bad   = 0;

  dispense_sequencer #(
    .CLK_FREQ (1000),
    .NUM_SLOTS(NS),
    .CNT_W    (4),
    .PUSH_MS  (5),
    .SETTLE_MS(2),
    .REVERT_MS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_slot  (cmd_slot),
    .cmd_count (cmd_count),
    .abort     (abort),
    .servo_ctrl(servo_ctrl),
    .busy      (busy),
    .units_left(units_left),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected servo word for cycle k (1..13) of a single unit on slot s.
  function automatic logic [31:0] unit_servo(input int k, input int s);
    logic [31:0] code;
    if (k <= 5)       code = 32'd1;
    else if (k <= 7)  code = 32'd0;
    else if (k <= 11) code = 32'd2;
    else              code = 32'd0;
    return code << (2 * s);
  endfunction

  task automatic issue(input int slot, input int count);
    cmd_valid = 1'b1;
    cmd_slot  = SW'(slot);
    cmd_count = 4'(count);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in cycle T+1 after acceptance; ends in cycle T+15.
  task automatic expect_one_unit(input int slot);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("unit_servo_s%0d_k%0d", slot, k), servo_ctrl, unit_servo(k, slot));
      chk($sformatf("unit_busy_k%0d", k), busy, 1);
      tick();
    end
    chk("unit_done", done, 1);
    chk("unit_err", err, 0);
    chk("unit_busy_end", busy, 0);
    chk("unit_ready_end", cmd_ready, 1);
    chk("unit_servo_end", servo_ctrl, 0);
    tick();
    chk("unit_done_clear", done, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_slot = '0; cmd_count = '0; abort = 1'b0;
    tick(); tick(); tick();
    chk("rst_servo", servo_ctrl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_units", units_left, 0);
    chk("rst_ready_in_reset", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", cmd_ready, 1);
    tick();

    // Single unit on slot 2.
    issue(2, 1);
    expect_one_unit(2);

    // Three units on slot 0 with an ignored command mid-run.
    issue(0, 3);
    for (int k = 1; k <= 39; k++) begin
      chk($sformatf("multi_units_k%0d", k), units_left, 32'(3 - (k - 1) / 13));
      chk($sformatf("multi_busy_k%0d", k), busy, 1);
      if (k == 5) begin
        cmd_valid = 1'b1; cmd_slot = SW'(1); cmd_count = 4'd2;
      end
      if (k == 6) cmd_valid = 1'b0;
      tick();
    end
    chk("multi_done", done, 1);
    chk("multi_err", err, 0);
    chk("multi_units_end", units_left, 0);
    tick();
    chk("multi_no_queue_busy", busy, 0);
    chk("multi_no_queue_servo", servo_ctrl, 0);

    // Zero count and out-of-range slot.
    issue(1, 0);
    chk("zero_done", done, 1);
    chk("zero_err", err, 0);
    chk("zero_busy", busy, 0);
    chk("zero_servo", servo_ctrl, 0);
    issue(5, 3);
    chk("badslot_done", done, 1);
    chk("badslot_err", err, 1);
    chk("badslot_busy", busy, 0);
    chk("badslot_servo", servo_ctrl, 0);
    tick();
    chk("badslot_done_clear", done, 0);
    chk("badslot_err_clear", err, 0);

    // Abort during PUSH on slot 3, count 2.
    issue(3, 2);
    tick(); tick();
    chk("abort_push_before", servo_ctrl, 32'd1 << 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 4; k <= 9; k++) begin
      chk($sformatf("abort_servo_k%0d", k), servo_ctrl, (k <= 7) ? (32'd2 << 6) : 32'd0);
      chk($sformatf("abort_done_k%0d", k), done, 0);
      tick();
    end
    chk("abort_done", done, 1);
    chk("abort_err", err, 1);
    chk("abort_busy", busy, 0);
    tick();

    // Abort with cmd_valid in IDLE: command is accepted, then reset mid-PUSH.
    abort = 1'b1;
    issue(4, 1);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1);
    chk("idle_abort_servo", servo_ctrl, 32'd1 << 8);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_servo", servo_ctrl, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_units", units_left, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", cmd_ready, 1);
    tick();
    issue(1, 1);
    expect_one_unit(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
